acc_loop_seq: RTL and testbench

Parametrised sequencer for the FHEW accumulator (ACAP) loop. It runs one full blind-rotation iteration n_iter times: INTT, then signed-digit decomposition streaming, then parallel NTTs, then key-multiply/accumulate streaming. It drives the external INTT, NTTN and MAC datapaths purely through start/done handshakes and generates their bank addresses. It generalises the earlier fixed-size, free-running controller with:
- ring/PE/digit parameters
- an iteration counter
- sticky multi-NTT completion tracking
- an optional watchdog

---
 rtl/acc_pkg.sv | 22 ++
 rtl/acc_stream_cnt.sv | 90 +++++++++
 rtl/acc_loop_seq.sv | 213 +++++++++++++++++++++
 tb/tb_acc_loop_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// acc_pkg: shared definitions for the FHEW accumulator-loop sequencer.
//   acc_state_e : sequencer FSM states
//   ADDR_W, L   : stream address width and stream length for the default ring/PE split
//                 (RING_DEPTH=10, PE_DEPTH=3 -> 7-bit addresses, 128 beats per stream)
package acc_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StIntt = 3'd1,
    StDec  = 3'd2,
    StNtt  = 3'd3,
    StMac  = 3'd4,
    StFin  = 3'd5
  } acc_state_e;

  localparam int unsigned RingDepthDef = 10;
  localparam int unsigned PeDepthDef   = 3;

  localparam int unsigned ADDR_W = RingDepthDef - PeDepthDef;
  localparam int unsigned L      = 1 << ADDR_W;

endpackage

// File: rtl/acc_stream_cnt.sv
// acc_stream_cnt: stream counter shared by the DEC and MAC phases.
// A start pulse launches one phase of 2^AddrW + StageDelay cycles. The first 2^AddrW cycles
// carry a valid beat with addr = beat index; the remaining cycles drain the pipeline with
// addr held at 0. sel_i picks which valid bit the phase drives (0: DEC, 1: MAC).
// All outputs are registered and describe the current phase cycle.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   start_i      launch a phase; first phase cycle follows the next edge
//   sel_i        phase selector, sampled with start_i
//   valid_o[1:0] {mac beat valid, dec beat valid}
//   addr_o       stream address
//   last_o       high in the final cycle of the phase
module acc_stream_cnt
  import acc_pkg::*;
#(
  parameter int unsigned AddrW      = ADDR_W,
  parameter int unsigned StageDelay = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             sel_i,
  output logic [1:0]       valid_o,
  output logic [AddrW-1:0] addr_o,
  output logic             last_o
);

  localparam int unsigned Len   = 1 << AddrW;
  localparam int unsigned Total = Len + StageDelay;
  localparam int unsigned CntW  = $clog2(Total + 1);

  localparam logic [CntW-1:0] LenC  = CntW'(Len);
  localparam logic [CntW-1:0] LastC = CntW'(Total - 1);

  logic            active_q, active_d;
  logic            sel_q, sel_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      valid_q, valid_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic            last_q, last_d;
  logic            in_stream;

  always_comb begin
    active_d = active_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      active_d = 1'b1;
      sel_d    = sel_i;
      cnt_d    = '0;
    end else if (active_q) begin
      if (cnt_q == LastC) begin
        active_d = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Outputs are decoded from the next count so they line up with the phase cycle.
    in_stream = active_d && (cnt_d < LenC);
    valid_d   = 2'b00;
    if (in_stream) valid_d = sel_d ? 2'b10 : 2'b01;
    addr_d = in_stream ? cnt_d[AddrW-1:0] : '0;
    last_d = active_d && (cnt_d == LastC);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      active_q <= 1'b0;
      sel_q    <= 1'b0;
      cnt_q    <= '0;
      valid_q  <= 2'b00;
      addr_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      addr_q   <= addr_d;
      last_q   <= last_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign last_o  = last_q;

endmodule

// File: rtl/acc_loop_seq.sv
// acc_loop_seq: sequencer for the FHEW accumulator (blind-rotation) loop.
// Each iteration: INTT -> decomposition stream -> parallel NTTs -> key-multiply/accumulate
// stream; repeated n_iter times. External datapaths are driven only by start/done
// handshakes plus the shared stream address.
// Optional build macro: ACC_SEQ_WDOG_EN enables a watchdog on the INTT/NTT waits; when it
// expires err is set, done pulses and the sequencer returns to idle. Without it err is 0.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   start, n_iter         run request (ignored while busy) and iteration count
//   intt_start/intt_done  INTT handshake
//   dec_valid             decomposer beat valid
//   ntt_start/ntt_done    parallel NTT handshake (per-instance done, any order)
//   mac_valid             key-multiply beat valid
//   addr                  stream address for DEC/MAC beats
//   iter_cnt              completed iterations
//   busy, done, err       status: not idle, end-of-run pulse, watchdog fired (sticky)
module acc_loop_seq
  import acc_pkg::*;
#(
  parameter int unsigned RING_DEPTH  = 10,
  parameter int unsigned PE_DEPTH    = 3,
  parameter int unsigned NTT_NUMBER  = 4,
  parameter int unsigned STAGE_DELAY = 8,
  parameter int unsigned ITER_W      = 10,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [ITER_W-1:0]              n_iter,
  output logic                           intt_start,
  input  logic                           intt_done,
  output logic                           dec_valid,
  output logic [NTT_NUMBER-1:0]          ntt_start,
  input  logic [NTT_NUMBER-1:0]          ntt_done,
  output logic                           mac_valid,
  output logic [RING_DEPTH-PE_DEPTH-1:0] addr,
  output logic [ITER_W-1:0]              iter_cnt,
  output logic                           busy,
  output logic                           done,
  output logic                           err
);

  localparam int unsigned StrmAddrW = RING_DEPTH - PE_DEPTH;

  acc_state_e            state_q, state_d;
  logic [ITER_W-1:0]     n_iter_q, n_iter_d;
  logic [ITER_W-1:0]     iter_cnt_q, iter_cnt_d;
  logic [ITER_W-1:0]     iter_next;
  logic [NTT_NUMBER-1:0] nd_q, nd_d, nd_all;
  logic                  intt_start_q, intt_start_d;
  logic [NTT_NUMBER-1:0] ntt_start_q, ntt_start_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  strm_start, strm_sel, strm_last;
  logic [1:0]            strm_valid;

`ifdef ACC_SEQ_WDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d      = state_q;
    n_iter_d     = n_iter_q;
    iter_cnt_d   = iter_cnt_q;
    nd_d         = nd_q;
    intt_start_d = 1'b0;
    ntt_start_d  = '0;
    done_d       = 1'b0;
    strm_start   = 1'b0;
    strm_sel     = 1'b0;
    iter_next    = iter_cnt_q + 1'b1;
    // Completion seen so far, including this cycle's pulses.
    nd_all       = nd_q | ntt_done;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_iter_d   = n_iter;
          iter_cnt_d = '0;
          if (n_iter == '0) begin
            state_d = StFin;
          end else begin
            state_d      = StIntt;
            intt_start_d = 1'b1;
          end
        end
      end
      StIntt: begin
        if (intt_done) begin
          state_d    = StDec;
          strm_start = 1'b1;
        end
      end
      StDec: begin
        if (strm_last) begin
          state_d     = StNtt;
          ntt_start_d = {NTT_NUMBER{1'b1}};
        end
      end
      StNtt: begin
        if (&nd_all) begin
          nd_d       = '0;
          state_d    = StMac;
          strm_start = 1'b1;
          strm_sel   = 1'b1;
        end else begin
          nd_d = nd_all;
        end
      end
      StMac: begin
        if (strm_last) begin
          iter_cnt_d = iter_next;
          if (iter_next == n_iter_q) begin
            state_d = StFin;
          end else begin
            state_d      = StIntt;
            intt_start_d = 1'b1;
          end
        end
      end
      StFin: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef ACC_SEQ_WDOG_EN
    err_d = err_q;
    if (state_q == StIdle && start) err_d = 1'b0;
    // Counts only while parked in a wait state; any state change restarts it.
    wd_d = '0;
    if ((state_q == StIntt || state_q == StNtt) && state_d == state_q) begin
      if (wd_q == WdLast) begin
        state_d = StIdle;
        done_d  = 1'b1;
        err_d   = 1'b1;
        nd_d    = '0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      n_iter_q     <= '0;
      iter_cnt_q   <= '0;
      nd_q         <= '0;
      intt_start_q <= 1'b0;
      ntt_start_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef ACC_SEQ_WDOG_EN
      wd_q         <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      n_iter_q     <= n_iter_d;
      iter_cnt_q   <= iter_cnt_d;
      nd_q         <= nd_d;
      intt_start_q <= intt_start_d;
      ntt_start_q  <= ntt_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef ACC_SEQ_WDOG_EN
      wd_q         <= wd_d;
      err_q        <= err_d;
`endif
    end
  end

  acc_stream_cnt #(
    .AddrW      (StrmAddrW),
    .StageDelay (STAGE_DELAY)
  ) u_stream_cnt (
    .clk     (clk),
    .reset   (reset),
    .start_i (strm_start),
    .sel_i   (strm_sel),
    .valid_o (strm_valid),
    .addr_o  (addr),
    .last_o  (strm_last)
  );

  assign intt_start = intt_start_q;
  assign ntt_start  = ntt_start_q;
  assign dec_valid  = strm_valid[0];
  assign mac_valid  = strm_valid[1];
  assign iter_cnt   = iter_cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef ACC_SEQ_WDOG_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_acc_loop_seq.sv
// Directed bench for acc_loop_seq with RING_DEPTH=10, PE_DEPTH=3, STAGE_DELAY=8 (L=128)
// and TIMEOUT=64. A table of whole-run scenarios is replayed through a cycle-stepped driver
// that also answers the INTT/NTT handshakes; reset-in-NTT and watchdog are hand sequences.
module tb_acc_loop_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [9:0] n_iter = '0;
  logic       intt_done = 1'b0;
  logic [3:0] ntt_done = '0;
  logic       intt_start, dec_valid, mac_valid, busy, done, err;
  logic [3:0] ntt_start;
  logic [6:0] addr;
  logic [9:0] iter_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Per-run observations.
  int n_intt, n_ntt, n_dec, n_mac, n_done, done_at, addr_err, len_err, busy_err;

  typedef struct {
    int n;
    int lat;
    int d0, d1, d2, d3;
    bit spur;
    int e_iter;
    int e_intt;
    int e_dec;
    int e_mac;
    int e_done_at;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  acc_loop_seq #(
    .RING_DEPTH  (10),
    .PE_DEPTH    (3),
    .NTT_NUMBER  (4),
    .STAGE_DELAY (8),
    .ITER_W      (10),
    .TIMEOUT     (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .n_iter     (n_iter),
    .intt_start (intt_start),
    .intt_done  (intt_done),
    .dec_valid  (dec_valid),
    .ntt_start  (ntt_start),
    .ntt_done   (ntt_done),
    .mac_valid  (mac_valid),
    .addr       (addr),
    .iter_cnt   (iter_cnt),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cycle 0 is the cycle right after start is sampled. Outputs are sampled 1 time unit
  // after each edge; inputs set there are seen at the following edge.
  task automatic run_vec(input vec_t v);
    int cyc, t_intt, t_ntt, dec_first, mac_first, dec_idx, mac_idx;
    logic [3:0] nd;
    n_intt = 0; n_ntt = 0; n_dec = 0; n_mac = 0; n_done = 0;
    done_at = -1; addr_err = 0; len_err = 0; busy_err = 0;
    t_intt = -1000; t_ntt = -1000; dec_first = -1; mac_first = -1; dec_idx = 0; mac_idx = 0;
    n_iter = 10'(v.n);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (cyc < 1500 && !(done_at >= 0 && cyc >= done_at + 3)) begin
      if (intt_start) begin
        n_intt++;
        if (mac_first >= 0 && cyc - mac_first != 136) len_err++;
        mac_first = -1;
        t_intt = cyc;
      end
      if (ntt_start != 4'h0) begin
        n_ntt++;
        if (ntt_start != 4'hf) len_err++;
        if (dec_first < 0 || cyc - dec_first != 136) len_err++;
        dec_first = -1;
        t_ntt = cyc;
      end
      if (dec_valid) begin
        if (dec_first < 0) begin dec_first = cyc; dec_idx = 0; end
        if (int'(addr) != dec_idx) addr_err++;
        dec_idx++;
        n_dec++;
      end
      if (mac_valid) begin
        if (mac_first < 0) begin mac_first = cyc; mac_idx = 0; end
        if (int'(addr) != mac_idx) addr_err++;
        mac_idx++;
        n_mac++;
      end
      if (!dec_valid && !mac_valid && addr != 7'd0) addr_err++;
      if (dec_valid && mac_valid) addr_err++;
      if (done) begin
        n_done++;
        if (done_at < 0) begin
          done_at = cyc;
          if (mac_first >= 0 && cyc - mac_first != 137) len_err++;
          mac_first = -1;
        end
      end
      if (done_at >= 0 ? busy : !busy) busy_err++;

      intt_done = (cyc == t_intt + v.lat) ||
                  (v.spur && dec_first >= 0 && cyc == dec_first + 20);
      nd = 4'h0;
      if (cyc == t_ntt + v.d0) nd[0] = 1'b1;
      if (cyc == t_ntt + v.d1) nd[1] = 1'b1;
      if (cyc == t_ntt + v.d2) nd[2] = 1'b1;
      if (cyc == t_ntt + v.d3) nd[3] = 1'b1;
      if (v.spur && cyc == t_ntt + v.d0 + 1) nd[0] = 1'b1;
      if (v.spur && dec_first >= 0 && cyc == dec_first + 30) nd = 4'hf;
      ntt_done = nd;
      start  = v.spur && mac_first >= 0 && cyc == mac_first + 10;
      n_iter = start ? 10'd7 : 10'(v.n);
      tick();
      cyc++;
    end
    intt_done = 1'b0;
    ntt_done  = 4'h0;
    start     = 1'b0;
  endtask

  initial begin
    int k;
    int seen;

    // n, lat, d0..d3, spur, iter, intt pulses, dec beats, mac beats, done cycle
    vecs[0] = '{1, 5, 3, 7, 2, 9, 1'b0, 1, 1, 128, 128, 289};
    vecs[1] = '{0, 5, 3, 7, 2, 9, 1'b0, 0, 0, 0, 0, 1};
    vecs[2] = '{3, 5, 3, 7, 2, 9, 1'b0, 3, 3, 384, 384, 865};
    vecs[3] = '{2, 1, 0, 0, 0, 0, 1'b0, 2, 2, 256, 256, 551};
    vecs[4] = '{1, 12, 4, 4, 4, 4, 1'b0, 1, 1, 128, 128, 291};
    vecs[5] = '{1, 5, 3, 7, 2, 9, 1'b1, 1, 1, 128, 128, 289};

    tick();
    tick();
    check("reset intt_start", int'(intt_start), 0);
    check("reset dec_valid", int'(dec_valid), 0);
    check("reset ntt_start", int'(ntt_start), 0);
    check("reset mac_valid", int'(mac_valid), 0);
    check("reset addr", int'(addr), 0);
    check("reset iter_cnt", int'(iter_cnt), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset err", int'(err), 0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      check($sformatf("v%0d iter_cnt", i), int'(iter_cnt), vecs[i].e_iter);
      check($sformatf("v%0d intt_start pulses", i), n_intt, vecs[i].e_intt);
      check($sformatf("v%0d ntt_start pulses", i), n_ntt, vecs[i].e_intt);
      check($sformatf("v%0d dec beats", i), n_dec, vecs[i].e_dec);
      check($sformatf("v%0d mac beats", i), n_mac, vecs[i].e_mac);
      check($sformatf("v%0d done pulses", i), n_done, 1);
      check($sformatf("v%0d done cycle", i), done_at, vecs[i].e_done_at);
      check($sformatf("v%0d addr errors", i), addr_err, 0);
      check($sformatf("v%0d phase length errors", i), len_err, 0);
      check($sformatf("v%0d busy errors", i), busy_err, 0);
      check($sformatf("v%0d err", i), int'(err), 0);
    end

    // Reset while in NTT with two completion bits already recorded.
    n_iter = 10'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    intt_done = 1'b1;
    tick();
    intt_done = 1'b0;
    k = 0;
    while (ntt_start == 4'h0 && k < 400) begin tick(); k++; end
    check("rst run1 ntt_start", int'(ntt_start), 15);
    ntt_done = 4'b0011;
    tick();
    ntt_done = 4'h0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst busy", int'(busy), 0);
    check("rst ntt_start", int'(ntt_start), 0);
    check("rst mac_valid", int'(mac_valid), 0);
    check("rst dec_valid", int'(dec_valid), 0);
    check("rst intt_start", int'(intt_start), 0);
    check("rst done", int'(done), 0);
    check("rst iter_cnt", int'(iter_cnt), 0);
    reset = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst run2 intt_start", int'(intt_start), 1);
    intt_done = 1'b1;
    tick();
    intt_done = 1'b0;
    k = 0;
    while (ntt_start == 4'h0 && k < 400) begin tick(); k++; end
    check("rst run2 ntt_start", int'(ntt_start), 15);
    ntt_done = 4'b1100;
    tick();
    ntt_done = 4'h0;
    seen = 0;
    repeat (20) begin
      if (mac_valid) seen = 1;
      tick();
    end
    check("rst run2 waits for all bits", seen, 0);
    ntt_done = 4'b0011;
    tick();
    ntt_done = 4'h0;
    check("rst run2 mac 1 cycle after last ntt_done", int'(mac_valid), 1);
    k = 0;
    while (!done && k < 400) begin tick(); k++; end
    check("rst run2 done", int'(done), 1);
    check("rst run2 iter_cnt", int'(iter_cnt), 1);
    tick();

`ifdef ACC_SEQ_WDOG_EN
    // Withhold NTT bit 2: watchdog must end the run 64 cycles after NTT entry.
    n_iter = 10'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    intt_done = 1'b1;
    tick();
    intt_done = 1'b0;
    k = 0;
    while (ntt_start == 4'h0 && k < 400) begin tick(); k++; end
    check("wdog ntt_start", int'(ntt_start), 15);
    ntt_done = 4'b1011;
    tick();
    ntt_done = 4'h0;
    k = 1;
    while (!done && k < 200) begin tick(); k++; end
    check("wdog done offset", k, 64);
    check("wdog err", int'(err), 1);
    check("wdog busy", int'(busy), 0);
    tick();
    tick();
    check("wdog err sticky", int'(err), 1);
    check("wdog no mac", int'(mac_valid), 0);
    n_iter = 10'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("wdog err cleared by start", int'(err), 0);
    k = 0;
    while (!done && k < 10) begin tick(); k++; end
    check("wdog rerun done", int'(done), 1);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
